// File: rtl/rotary_decoder.sv
// Quadrature rotary-encoder decoder.
// Counts full detents, reports the direction of each completed detent,
// pulses on push-button presses and flags illegal two-bit jumps.
//
// state  | meaning
// DETENT | resting at AB=00, waiting for the first edge of a detent
// CW1    | CW sequence, AB=10 seen
// CW2    | CW sequence, AB=11 seen
// CW3    | CW sequence, AB=01 seen; AB=00 completes a CW detent
// CCW1   | CCW sequence, AB=01 seen
// CCW2   | CCW sequence, AB=11 seen
// CCW3   | CCW sequence, AB=10 seen; AB=00 completes a CCW detent
// RESYNC | illegal jump seen, waiting for AB=00 before counting again
module rotary_decoder #(
    parameter int WIDTH        = 8,
    parameter bit WRAP         = 1'b1,
    parameter bit CLR_ON_PRESS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rotA,
    input  logic             rotB,
    input  logic             rotCTR,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             dir,
    output logic             press,
    output logic             err
);

    typedef enum logic [2:0] {
        DETENT, CW1, CW2, CW3, CCW1, CCW2, CCW3, RESYNC
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           next_state;
    logic             a_q;
    logic             b_q;
    logic             ctr_q;
    logic             ctr_prev;
    logic [1:0]       ab;
    logic             do_step;
    logic             step_cw;
    logic             bad;
    logic             press_now;
    logic [WIDTH-1:0] count_next;

    assign ab        = {a_q, b_q};
    assign press_now = ctr_q & ~ctr_prev;

    // Input registers plus the delayed button level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            ctr_q    <= 1'b0;
            ctr_prev <= 1'b0;
        end else begin
            a_q      <= rotA;
            b_q      <= rotB;
            ctr_q    <= rotCTR;
            ctr_prev <= ctr_q;
        end
    end

    // Transition decode: next state, detent completion and illegal jumps.
    always_comb begin
        next_state = state;
        do_step    = 1'b0;
        step_cw    = 1'b0;
        bad        = 1'b0;
        case (state)
            DETENT: begin
                if (ab == 2'b10)      next_state = CW1;
                else if (ab == 2'b01) next_state = CCW1;
                else if (ab == 2'b11) begin next_state = RESYNC; bad = 1'b1; end
            end
            CW1: begin
                if (ab == 2'b11)      next_state = CW2;
                else if (ab == 2'b00) next_state = DETENT;
                else if (ab == 2'b01) begin next_state = RESYNC; bad = 1'b1; end
            end
            CW2: begin
                if (ab == 2'b01)      next_state = CW3;
                else if (ab == 2'b10) next_state = CW1;
                else if (ab == 2'b00) begin next_state = RESYNC; bad = 1'b1; end
            end
            CW3: begin
                if (ab == 2'b00) begin
                    next_state = DETENT;
                    do_step    = 1'b1;
                    step_cw    = 1'b1;
                end
                else if (ab == 2'b11) next_state = CW2;
                else if (ab == 2'b10) begin next_state = RESYNC; bad = 1'b1; end
            end
            CCW1: begin
                if (ab == 2'b11)      next_state = CCW2;
                else if (ab == 2'b00) next_state = DETENT;
                else if (ab == 2'b10) begin next_state = RESYNC; bad = 1'b1; end
            end
            CCW2: begin
                if (ab == 2'b10)      next_state = CCW3;
                else if (ab == 2'b01) next_state = CCW1;
                else if (ab == 2'b00) begin next_state = RESYNC; bad = 1'b1; end
            end
            CCW3: begin
                if (ab == 2'b00) begin
                    next_state = DETENT;
                    do_step    = 1'b1;
                end
                else if (ab == 2'b11) next_state = CCW2;
                else if (ab == 2'b01) begin next_state = RESYNC; bad = 1'b1; end
            end
            RESYNC: begin
                if (ab == 2'b00) next_state = DETENT;
            end
            default: next_state = DETENT;
        endcase
    end

    // Next count: wrap or saturate on a step; a press clears and wins over a step.
    always_comb begin
        count_next = count;
        if (do_step) begin
            if (step_cw) begin
                if (count != CNT_MAX)  count_next = count + WIDTH'(1);
                else if (WRAP)         count_next = '0;
            end else begin
                if (count != '0)       count_next = count - WIDTH'(1);
                else if (WRAP)         count_next = CNT_MAX;
            end
        end
        if (CLR_ON_PRESS && press_now) count_next = '0;
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DETENT;
            count <= '0;
            step  <= 1'b0;
            dir   <= 1'b0;
            press <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            count <= count_next;
            step  <= do_step;
            press <= press_now;
            err   <= bad;
            if (do_step) dir <= step_cw;
        end
    end

endmodule

// File: tb/tb_rotary_decoder.sv
// Bench for rotary_decoder: two instances (wrapping + clear-on-press, and
// saturating without clear) share one stimulus and are compared every cycle
// against a position-progress model, plus directed literal expectations.
module tb_rotary_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rotA = 1'b0;
    logic       rotB = 1'b0;
    logic       rotCTR = 1'b0;

    logic [7:0] count0, count1;
    logic       step0, dir0, press0, err0;
    logic       step1, dir1, press1, err1;

    int n_checks = 0;
    int n_err = 0;

    rotary_decoder #(.WIDTH(8), .WRAP(1'b1), .CLR_ON_PRESS(1'b1)) dut0 (
        .clk(clk), .reset(reset), .rotA(rotA), .rotB(rotB), .rotCTR(rotCTR),
        .count(count0), .step(step0), .dir(dir0), .press(press0), .err(err0)
    );

    rotary_decoder #(.WIDTH(8), .WRAP(1'b0), .CLR_ON_PRESS(1'b0)) dut1 (
        .clk(clk), .reset(reset), .rotA(rotA), .rotB(rotB), .rotCTR(rotCTR),
        .count(count1), .step(step1), .dir(dir1), .press(press1), .err(err1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Position of an AB code along the CW sequence 00-10-11-01.
    function automatic int pos_of(input logic [1:0] ab);
        case (ab)
            2'b00: return 0;
            2'b10: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // Progress p counts quarter-steps away from the detent (+CW, -CCW);
    // reaching +-4 is a completed detent, a two-position jump is an error.
    logic [1:0] m_ab;
    logic       m_ctr, m_ctr_prev, m_resync;
    int         m_p;
    int         e_cnt0, e_cnt1;
    logic       e_step, e_dir, e_press, e_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ab = 2'b00; m_ctr = 1'b0; m_ctr_prev = 1'b0; m_resync = 1'b0;
            m_p = 0; e_cnt0 = 0; e_cnt1 = 0;
            e_step = 1'b0; e_dir = 1'b0; e_press = 1'b0; e_err = 1'b0;
        end else begin
            int d;
            e_step = 1'b0;
            e_err  = 1'b0;
            if (m_resync) begin
                if (m_ab == 2'b00) begin m_resync = 1'b0; m_p = 0; end
            end else begin
                d = (pos_of(m_ab) - ((m_p + 4) % 4) + 4) % 4;
                if (d == 1) m_p++;
                else if (d == 3) m_p--;
                else if (d == 2) begin m_resync = 1'b1; e_err = 1'b1; m_p = 0; end
                if (m_p == 4 || m_p == -4) begin
                    e_step = 1'b1;
                    e_dir  = (m_p > 0);
                    m_p    = 0;
                end
            end
            e_press = m_ctr & ~m_ctr_prev;
            if (e_step) begin
                if (e_dir) begin
                    e_cnt0 = (e_cnt0 + 1) % 256;
                    if (e_cnt1 < 255) e_cnt1++;
                end else begin
                    e_cnt0 = (e_cnt0 + 255) % 256;
                    if (e_cnt1 > 0) e_cnt1--;
                end
            end
            if (e_press) e_cnt0 = 0;
            m_ctr_prev = m_ctr;
            m_ctr      = rotCTR;
            m_ab       = {rotA, rotB};
        end
    end

    // ---------------- per-cycle compare and event counters ----------------
    int n_step0 = 0, n_err0 = 0, n_press0 = 0, n_step1 = 0;

    always @(negedge clk) begin
        check("count0", int'(count0), e_cnt0);
        check("count1", int'(count1), e_cnt1);
        check("step0",  int'(step0),  int'(e_step));
        check("step1",  int'(step1),  int'(e_step));
        check("dir0",   int'(dir0),   int'(e_dir));
        check("dir1",   int'(dir1),   int'(e_dir));
        check("press0", int'(press0), int'(e_press));
        check("press1", int'(press1), int'(e_press));
        check("err0",   int'(err0),   int'(e_err));
        check("err1",   int'(err1),   int'(e_err));
        if (step0)  n_step0++;
        if (err0)   n_err0++;
        if (press0) n_press0++;
        if (step1)  n_step1++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_ab(input logic [1:0] v, input int n);
        {rotA, rotB} = v;
        cyc(n);
    endtask

    task automatic cw_detent(input int n);
        set_ab(2'b10, n); set_ab(2'b11, n); set_ab(2'b01, n); set_ab(2'b00, n);
    endtask

    task automatic ccw_detent(input int n);
        set_ab(2'b01, n); set_ab(2'b11, n); set_ab(2'b10, n); set_ab(2'b00, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    logic [1:0] cw_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    initial begin
        int b_step, b_err, b_press, b_step1;
        logic [1:0] cur;

        // Reset state
        cyc(2);
        check("rst_count0", int'(count0), 0);
        check("rst_dir0", int'(dir0), 0);
        reset = 1'b0;
        cyc(2);

        // One CW detent, each code held 4 cycles
        b_step = n_step0;
        cw_detent(4);
        check("cw_steps", n_step0 - b_step, 1);
        check("cw_count", int'(count0), 1);
        check("cw_dir", int'(dir0), 1);

        // CCW from 0: wrap to 255, saturate at 0
        do_reset();
        b_step1 = n_step1;
        ccw_detent(3);
        check("ccw_wrap_count", int'(count0), 255);
        check("ccw_dir", int'(dir0), 0);
        check("ccw_sat_count", int'(count1), 0);
        check("ccw_sat_steps", n_step1 - b_step1, 1);

        // Backtracks: no step, no err
        b_step = n_step0; b_err = n_err0;
        set_ab(2'b10, 3); set_ab(2'b00, 3);
        set_ab(2'b10, 3); set_ab(2'b11, 3); set_ab(2'b10, 3); set_ab(2'b00, 3);
        check("bt_steps", n_step0 - b_step, 0);
        check("bt_errs", n_err0 - b_err, 0);
        check("bt_count", int'(count0), 255);

        // Illegal jump, resync, then a good detent
        do_reset();
        b_step = n_step0; b_err = n_err0;
        set_ab(2'b11, 3);
        check("jump_errs", n_err0 - b_err, 1);
        set_ab(2'b01, 3); set_ab(2'b00, 3);
        check("resync_steps", n_step0 - b_step, 0);
        cw_detent(2);
        check("resync_cw_count", int'(count0), 1);

        // Press clears, held button pulses once; press coincident with step
        do_reset();
        repeat (5) cw_detent(2);
        check("five_count", int'(count0), 5);
        b_press = n_press0;
        rotCTR = 1'b1;
        cyc(20);
        check("hold_presses", n_press0 - b_press, 1);
        check("press_count0", int'(count0), 0);
        check("press_count1", int'(count1), 5);
        rotCTR = 1'b0;
        cyc(2);
        set_ab(2'b10, 2); set_ab(2'b11, 2); set_ab(2'b01, 2);
        {rotA, rotB} = 2'b00;
        rotCTR = 1'b1;
        cyc(2);
        check("coinc_step", int'(step0), 1);
        check("coinc_press", int'(press0), 1);
        check("coinc_count0", int'(count0), 0);
        check("coinc_dir", int'(dir0), 1);
        check("coinc_count1", int'(count1), 6);
        rotCTR = 1'b0;
        cyc(3);

        // Reset mid-detent abandons the partial sequence
        do_reset();
        repeat (7) cw_detent(2);
        set_ab(2'b10, 3); set_ab(2'b11, 3);
        check("mid_count", int'(count0), 7);
        reset = 1'b1;
        #1;
        check("async_rst_count", int'(count0), 0);
        cyc(2);
        reset = 1'b0;
        b_step = n_step0;
        set_ab(2'b01, 2); set_ab(2'b00, 4);
        check("mid_rst_steps", n_step0 - b_step, 0);
        check("mid_rst_count", int'(count0), 0);

        // AB=11 at reset release -> err
        {rotA, rotB} = 2'b11;
        reset = 1'b1;
        cyc(2);
        b_err = n_err0;
        reset = 1'b0;
        cyc(4);
        check("rel11_errs", n_err0 - b_err, 1);
        set_ab(2'b00, 3);

        // Randomized walk against the model
        cur = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            int r;
            int bias;
            r = $urandom_range(0, 99);
            bias = (i / 500) % 2;
            if (r < 35) begin
                // hold
            end else if (r < 90) begin
                if ((r < 70) == (bias == 0)) cur = cw_seq[(pos_of(cur) + 1) % 4];
                else                         cur = cw_seq[(pos_of(cur) + 3) % 4];
            end else if (r < 94) begin
                cur = ~cur;
            end
            {rotA, rotB} = cur;
            if ($urandom_range(0, 99) < 4) rotCTR = ~rotCTR;
            if ($urandom_range(0, 999) < 4) reset = 1'b1;
            cyc($urandom_range(1, 3));
            reset = 1'b0;
        end
        cyc(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rotary_decoder.md
ROTARY_DECODER -- requirements
Module: rotary_decoder

Interface
REQ-001 Parameter WIDTH, default 8, width of the position count.
REQ-002 Parameter WRAP, default 1; 1 = count wraps modulo 2^WIDTH, 0 = count saturates at 0 and 2^WIDTH-1.
REQ-003 Parameter CLR_ON_PRESS, default 1; 1 = a detected press clears count to 0.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rotA  input  1  debounced encoder channel A, from the rotary debouncer.
REQ-007 rotB  input  1  debounced encoder channel B, from the rotary debouncer.
REQ-008 rotCTR  input  1  debounced centre push-button level, 1 = pressed.
REQ-009 count  output  WIDTH  current position count.
REQ-010 step  output  1  one-cycle pulse per completed detent.
REQ-011 dir  output  1  direction of the last completed detent, 1 = CW, 0 = CCW.
REQ-012 press  output  1  one-cycle pulse on rotCTR rising edge.
REQ-013 err  output  1  one-cycle pulse on an illegal quadrature transition.

Function
REQ-014 rotA, rotB and rotCTR shall each be registered once before use; AB denotes {rotA,rotB} after this register.
REQ-015 Detent position shall be AB=00; CW sequence 00-10-11-01-00; CCW sequence 00-01-11-10-00.
REQ-016 FSM states: DETENT, CW1, CW2, CW3, CCW1, CCW2, CCW3, RESYNC; all outputs are registered.
REQ-017 DETENT: AB=10 -> CW1; AB=01 -> CCW1; AB=00 -> hold; AB=11 -> RESYNC with err pulse.
REQ-018 CW1: 11 -> CW2; 00 -> DETENT (backtrack, no step); 10 -> hold; 01 -> RESYNC with err.
REQ-019 CW2: 01 -> CW3; 10 -> CW1; 11 -> hold; 00 -> RESYNC with err.
REQ-020 CW3: 00 -> DETENT with step=1, dir=1; 11 -> CW2; 01 -> hold; 10 -> RESYNC with err.
REQ-021 CCW1/CCW2/CCW3 shall mirror REQ-018..020 with the CCW sequence and dir=0 on completion.
REQ-022 RESYNC shall hold until AB=00, then go to DETENT with no step and no further err.
REQ-023 Latency: step asserted in the cycle after the second rising clk edge following the raw inputs reaching 00 from CW3/CCW3 (1 input register + 1 FSM register).
REQ-024 On step with dir=1 count shall increment; with dir=0 decrement; in the same cycle step is high.
REQ-025 WRAP=1: 2^WIDTH-1 +1 -> 0 and 0 -1 -> 2^WIDTH-1; WRAP=0: increments at max and decrements at 0 leave count unchanged while step still pulses.
REQ-026 dir shall update only on a completed detent and hold otherwise.
REQ-027 press shall pulse for exactly one cycle when registered rotCTR goes 0->1; holding rotCTR high shall not repeat the pulse.
REQ-028 CLR_ON_PRESS=1: count becomes 0 in the press cycle; press has priority over a simultaneous step (step and dir still update, count=0).
REQ-029 step, press, err shall never be high for more than one consecutive cycle per event.

Reset
REQ-030 While reset is high: FSM = DETENT, count=0, dir=0, step=0, press=0, err=0, input registers=0, asynchronously.
REQ-031 Reset asserted mid-sequence shall abandon the partial detent; after release a full sequence from 00 is required for the next step.
REQ-032 If AB is not 00 at reset release, the FSM shall proceed per REQ-017 (e.g. AB=11 -> RESYNC, err pulse).

Verification
REQ-033 Reset, then AB 00-10-11-01-00 holding each 4 cycles -> one step pulse, dir=1, count=1.
REQ-034 Count=0, WRAP=1, one CCW detent -> count=255, dir=0; repeat with WRAP=0 -> count=0, step still pulses.
REQ-035 AB 00-10-00 then 00-10-11-10-00 -> no step, no err, count unchanged.
REQ-036 From DETENT jump AB 00-11 -> single err pulse, RESYNC; then 01-00 -> no step; next CW detent -> count+1.
REQ-037 Count=5, hold rotCTR high 20 cycles -> single press pulse, count=0; press coincident with CW step -> count=0, step=1, dir=1.
REQ-038 Assert reset at CW2 with count=7 -> count=0 immediately; release, AB 01-00 -> no step.
